fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO that succeeds the fixed 8×8 `fifo`. Width, depth and programmable almost-full/almost-empty margins are generics, and an occupancy count is exported. Sticky overflow/underflow error flags are added. A first-word-fall-through (FWFT) read mode is selectable. It sits between a single-clock producer and consumer as a drop-in buffer that keeps the `fifo` port names and adds new ports.

## Interface
- `WIDTH`, default 8: data word width in bits (≥1).
- `DEPTH`, default 8: number of entries; power of two, ≥4.
- `AF_MARGIN`, default 1: `almost_full` asserts when count ≥ DEPTH−AF_MARGIN; range 1..DEPTH−1.
- `AE_MARGIN`, default 1: `almost_empty` asserts when count ≤ AE_MARGIN; range 1..DEPTH−1.
- `FWFT`, default 0: 0 selects registered read; 1 selects first-word-fall-through.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `we`, input, 1: write request.
- `re`, input, 1: read (pop) request.
- `data_in`, input, WIDTH: write data.
- `clr_err`, input, 1: synchronous clear of `overflow` and `underflow`.
- `data_out`, output, WIDTH: read data.
- `full`, output, 1: count == DEPTH.
- `empty`, output, 1: count == 0.
- `half`, output, 1: count ≥ DEPTH/2.
- `almost_full`, output, 1: see `AF_MARGIN`.
- `almost_empty`, output, 1: see `AE_MARGIN`.
- `count`, output, log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky; a write was dropped.
- `underflow`, output, 1: sticky; a read was made while empty.

## Operation
- **Storage:** DEPTH×WIDTH array. Write and read pointers are log2(DEPTH) bits wide and wrap modulo DEPTH with no special case. The `count` register is kept separately.
- **Write accepted:** `we` && (!full || `re`). `data_in` is stored at wr_ptr, and wr_ptr increments.
- **Read accepted:** `re` && !empty. rd_ptr increments.
- **Count update:** +1 on an accepted write only; −1 on an accepted read only; unchanged when both or neither are accepted.
- **Simultaneous `we` and `re` when full:** both are accepted; count stays at DEPTH and no overflow is flagged.
- **Simultaneous `we` and `re` when empty:** the write is accepted and the read is rejected. Count becomes 1 and `underflow` sets.
- **Overflow:** `overflow` sets on `we` && full && !`re`. The write is discarded and memory is not modified.
- **Underflow:** `underflow` sets on `re` && empty. Pointers do not move.
- **Error clearing:** `clr_err` clears both error flags at the edge. If an error event occurs in the same cycle, the set wins.
- **FWFT=0:** on an accepted read, `data_out` registers mem[rd_ptr] at the edge. Otherwise `data_out` holds its value.
- **FWFT=1:** `data_out` = mem[rd_ptr] combinationally while !empty, and 0 while empty. Asserting `re` consumes the displayed word.
- **Status flags:** all are decoded from the registered `count`, so they carry no combinational path from `we` or `re`.

## Timing
- **Reset:** `rst` high clears pointers, `count`, `overflow`, `underflow` and the `data_out` register immediately, independent of `clk`. Resulting outputs: `empty`=1, `almost_empty`=1, `full`=0, `half`=0, `almost_full`=0, `count`=0, `data_out`=0. Memory contents are not reset. Reset mid-operation discards all stored data.
- **Write to read latency:** a word written at edge N is readable from edge N+1. With FWFT=0 it appears on `data_out` at the edge that accepts the read. With FWFT=1 it is visible on `data_out` after edge N, with no `re` needed.
- **Flag latency:** flags and `count` change on the same edge that accepts the transfer. There is no extra latency.
- **Throughput:** one write and one read per cycle, sustained.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, AF_MARGIN=1, AE_MARGIN=1.

- **Fill then drain, FWFT=0:** write 0x11..0x88 on 8 consecutive cycles.
  - After the 4th write `half`=1; after the 7th `almost_full`=1; after the 8th `full`=1 and `count`=8.
  - Then read 8 times: `data_out` gives 0x11..0x88 in order, and `empty`=1 after the 8th read.
- **Overflow:** with the FIFO full, assert `we` alone with 0xAA. `overflow`=1 and `count` stays 8. Draining returns 0x11..0x88 with no 0xAA. Pulsing `clr_err` then clears `overflow`.
- **Underflow:** `re` with the FIFO empty sets `underflow`=1 while `count` stays 0 and `data_out` is unchanged. `we`+`re` together when empty with 0x5C gives `count`=1 and `underflow`=1.
- **Wrap and simultaneous access:** write 6, read 6, then write 8 (pointers wrap). Apply `we`+`re` when full: `count` stays 8 and `full` stays 1. Read-out order is preserved across the wrap.
- **FWFT=1:** write 0x3C; one cycle later `data_out`=0x3C with no `re`. Write 0x4D, then pulse `re`: `data_out`=0x4D on the next cycle. A second `re` empties the FIFO and `data_out`=0.
- **Async reset mid-operation:** assert `rst` between clock edges with `count`=5. All outputs take their reset values before the next edge. Deassert `rst` and write 0x01: the next read returns 0x01.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a selectable registered or first-word-fall-through read port.
module fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 1,
   parameter int AE_MARGIN = 1,
   parameter int FWFT      = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic                       re,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       half,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Flag thresholds pre-sized to the count width so every compare is exact.
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);
   localparam logic [CW-1:0] AF_C    = CW'(DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] AE_C    = CW'(AE_MARGIN);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          overflow_reg;
   logic          underflow_reg;

   logic wr_acc;
   logic rd_acc;
   logic ovf_set;
   logic udf_set;

   // Transfer acceptance and error events; a write into a full FIFO is
   // accepted only when a read frees a slot in the same cycle.
   always_comb begin
      wr_acc  = we && (!full || re);
      rd_acc  = re && !empty;
      ovf_set = we && full && !re;
      udf_set = re && empty;
   end

   // Storage array: write port only, contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         // A new error event in the clear cycle keeps the flag set.
         if (ovf_set) begin
            overflow_reg <= 1'b1;
         end else if (clr_err) begin
            overflow_reg <= 1'b0;
         end
         if (udf_set) begin
            underflow_reg <= 1'b1;
         end else if (clr_err) begin
            underflow_reg <= 1'b0;
         end
      end
   end

   // Status flags decode only the registered count, so they are glitch-free
   // with respect to we/re.
   assign count        = count_reg;
   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign half         = (count_reg >= HALF_C);
   assign almost_full  = (count_reg >= AF_C);
   assign almost_empty = (count_reg <= AE_C);
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [WIDTH-1:0] data_out_reg;

         // Registered read: the popped word is captured on the accepting edge.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_out_reg <= '0;
            end else if (rd_acc) begin
               data_out_reg <= mem[rd_ptr_reg];
            end
         end

         assign data_out = data_out_reg;
      end else begin : g_fwft_read
         // Head of queue is shown directly; zero while there is nothing to show.
         assign data_out = empty ? '0 : mem[rd_ptr_reg];
      end
   endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a table of FWFT=0 vectors followed by
// hand-written async-reset and FWFT=1 sequences.
module tb_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       we0 = 1'b0, re0 = 1'b0, clr0 = 1'b0;
   logic [7:0] din0 = '0;
   logic [7:0] dout0;
   logic       full0, empty0, half0, af0, ae0, ovf0, udf0;
   logic [3:0] cnt0;

   logic       we1 = 1'b0, re1 = 1'b0, clr1 = 1'b0;
   logic [7:0] din1 = '0;
   logic [7:0] dout1;
   logic       full1, empty1, half1, af1, ae1, ovf1, udf1;
   logic [3:0] cnt1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fifo_param #(.WIDTH(8), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .we(we0), .re(re0), .data_in(din0), .clr_err(clr0),
      .data_out(dout0), .full(full0), .empty(empty0), .half(half0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ovf0), .underflow(udf0)
   );

   fifo_param #(.WIDTH(8), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .we(we1), .re(re1), .data_in(din1), .clr_err(clr1),
      .data_out(dout1), .full(full1), .empty(empty1), .half(half1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ovf1), .underflow(udf1)
   );

   typedef struct {
      logic       we;
      logic       re;
      logic       clr;
      logic [7:0] din;
      int         cnt;
      logic       ovf;
      logic       udf;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl[$];

   // Expected flag vector {full, empty, half, af, ae, ovf, udf} for DEPTH=8, margins 1.
   function automatic logic [6:0] exp_flags(int c, logic ovf, logic udf);
      return {c == 8, c == 0, c >= 4, c >= 7, c <= 1, ovf, udf};
   endfunction

   function automatic vec_t mk(logic we, logic re, logic clr, logic [7:0] din,
                               int cnt, logic ovf, logic udf, logic [7:0] dout);
      vec_t v;
      v.we = we; v.re = re; v.clr = clr; v.din = din;
      v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.dout = dout;
      return v;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   function automatic logic [6:0] flags0();
      return {full0, empty0, half0, af0, ae0, ovf0, udf0};
   endfunction

   function automatic logic [6:0] flags1();
      return {full1, empty1, half1, af1, ae1, ovf1, udf1};
   endfunction

   // One clock on dut0: drive at the falling edge, sample 1 ns after the rising edge.
   task automatic step0(logic we, logic re, logic clr, logic [7:0] din);
      @(negedge clk);
      we0 = we; re0 = re; clr0 = clr; din0 = din;
      @(posedge clk);
      #1;
      $display("dut0 we=%0b re=%0b clr=%0b din=%02h -> count=%0d dout=%02h flags=%07b",
               we, re, clr, din, cnt0, dout0, flags0());
   endtask

   task automatic step1(logic we, logic re, logic [7:0] din);
      @(negedge clk);
      we1 = we; re1 = re; clr1 = 1'b0; din1 = din;
      @(posedge clk);
      #1;
      $display("dut1 we=%0b re=%0b din=%02h -> count=%0d dout=%02h flags=%07b",
               we, re, din, cnt1, dout1, flags1());
   endtask

   initial begin
      // ---- vector table (FWFT=0) ----
      // fill 0x11..0x88
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(1, 0, 0, 8'(k * 8'h11), k, 0, 0, 8'h00));
      // overflow attempt with 0xAA
      tbl.push_back(mk(1, 0, 0, 8'hAA, 8, 1, 0, 8'h00));
      // drain: 0x11..0x88 and no 0xAA
      for (int j = 1; j <= 8; j++)
         tbl.push_back(mk(0, 1, 0, 8'h00, 8 - j, 1, 0, 8'(j * 8'h11)));
      // clear overflow
      tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h88));
      // underflow: read while empty
      tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 8'h88));
      // we+re when empty
      tbl.push_back(mk(1, 1, 0, 8'h5C, 1, 0, 1, 8'h88));
      tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 8'h5C));
      tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h5C));
      // wrap: write 6, read 6, write 8
      for (int k = 1; k <= 6; k++)
         tbl.push_back(mk(1, 0, 0, 8'(8'h20 + k), k, 0, 0, 8'h5C));
      for (int k = 1; k <= 6; k++)
         tbl.push_back(mk(0, 1, 0, 8'h00, 6 - k, 0, 0, 8'(8'h20 + k)));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(1, 0, 0, 8'(8'h30 + k), k, 0, 0, 8'h26));
      // we+re when full: count stays 8, head word popped
      tbl.push_back(mk(1, 1, 0, 8'h39, 8, 0, 0, 8'h31));
      for (int k = 2; k <= 9; k++)
         tbl.push_back(mk(0, 1, 0, 8'h00, 9 - k, 0, 0, 8'(8'h30 + k)));

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count0", 0, 32'(cnt0), 0);
      chk("rst_flags0", 0, 32'(flags0()), 32'(exp_flags(0, 0, 0)));
      chk("rst_dout0",  0, 32'(dout0), 0);
      chk("rst_dout1",  0, 32'(dout1), 0);
      @(negedge clk);
      rst = 1'b0;

      // ---- table ----
      for (int i = 0; i < tbl.size(); i++) begin
         step0(tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].din);
         chk("count", i, 32'(cnt0), 32'(tbl[i].cnt));
         chk("flags", i, 32'(flags0()), 32'(exp_flags(tbl[i].cnt, tbl[i].ovf, tbl[i].udf)));
         chk("dout",  i, 32'(dout0), 32'(tbl[i].dout));
      end

      // ---- async reset mid-operation ----
      for (int k = 1; k <= 6; k++) step0(1, 0, 0, 8'(8'h40 + k));
      step0(0, 1, 0, 8'h00);
      chk("pre_rst_count", 0, 32'(cnt0), 5);
      chk("pre_rst_dout",  0, 32'(dout0), 32'h41);
      @(negedge clk);
      we0 = 1'b0; re0 = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 0, 32'(cnt0), 0);
      chk("arst_flags", 0, 32'(flags0()), 32'(exp_flags(0, 0, 0)));
      chk("arst_dout",  0, 32'(dout0), 0);
      @(negedge clk);
      rst = 1'b0;
      step0(1, 0, 0, 8'h01);
      chk("post_rst_count", 0, 32'(cnt0), 1);
      step0(0, 1, 0, 8'h00);
      chk("post_rst_dout",  0, 32'(dout0), 32'h01);
      chk("post_rst_flags", 0, 32'(flags0()), 32'(exp_flags(0, 0, 0)));
      step0(0, 0, 0, 8'h00);

      // ---- FWFT=1 ----
      chk("fwft_idle_dout", 0, 32'(dout1), 0);
      step1(1, 0, 8'h3C);
      chk("fwft_first", 0, 32'(dout1), 32'h3C);
      step1(1, 0, 8'h4D);
      chk("fwft_hold", 0, 32'(dout1), 32'h3C);
      chk("fwft_cnt2", 0, 32'(cnt1), 2);
      step1(0, 1, 8'h00);
      chk("fwft_pop1", 0, 32'(dout1), 32'h4D);
      chk("fwft_cnt1", 0, 32'(cnt1), 1);
      step1(0, 1, 8'h00);
      chk("fwft_empty_dout", 0, 32'(dout1), 0);
      chk("fwft_empty_flags", 0, 32'(flags1()), 32'(exp_flags(0, 0, 0)));
      step1(0, 1, 8'h00);
      chk("fwft_udf_flags", 0, 32'(flags1()), 32'(exp_flags(0, 0, 1)));
      chk("fwft_udf_dout",  0, 32'(dout1), 0);
      step1(0, 0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
